// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter and its load queue.
package wb_arbiter_pkg;

  localparam logic        RESET_EN         = 1'b0;  // rstn level that resets
  localparam logic        W_REG_EN         = 1'b1;  // register-file write enable level
  localparam int unsigned XLEN             = 32;
  localparam int unsigned REG_IDX_W        = 5;
  localparam int unsigned NUM_REGS         = 32;
  localparam int unsigned LQ_DEPTH_DEFAULT = 4;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  // Slot usage for one cycle, decided by how many ALUs claim a write port.
  typedef enum logic [1:0] {
    ModeDrain,  // no ALU: up to two LQ entries drain
    ModeMixed,  // one ALU: LQ head on port0, ALU on port1
    ModeAlus    // two ALUs: both ports taken, LQ waits
  } wb_mode_e;

  typedef struct packed {
    logic                 wen;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_port_t;

  localparam wb_port_t PORT_IDLE = '{wen: ~W_REG_EN, rd: ZERO_REG, data: '0};

endpackage

// File: rtl/wb_load_queue.sv
// Circular load queue with per-entry live bits, WAW kill by destination match,
// head/head+1 read ports and a pending-load bitmap over the live entries.
module wb_load_queue
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEFAULT,
  parameter int unsigned LQ_PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push,
  input  logic [REG_IDX_W-1:0] push_rd,
  input  logic [XLEN-1:0]      push_data,
  input  logic [1:0]           pop_cnt,
  input  logic                 kill0_en,
  input  logic [REG_IDX_W-1:0] kill0_rd,
  input  logic                 kill1_en,
  input  logic [REG_IDX_W-1:0] kill1_rd,
  output logic [LQ_PTR_W:0]    count,
  output logic                 head0_valid,
  output logic                 head0_live,
  output logic [REG_IDX_W-1:0] head0_rd,
  output logic [XLEN-1:0]      head0_data,
  output logic                 head1_valid,
  output logic                 head1_live,
  output logic [REG_IDX_W-1:0] head1_rd,
  output logic [XLEN-1:0]      head1_data,
  output logic [NUM_REGS-1:0]  pending
);

  logic [REG_IDX_W-1:0] rd_q   [LQ_DEPTH];
  logic [XLEN-1:0]      data_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]  live_q, live_d;
  logic [LQ_PTR_W-1:0]  head_q, tail_q, head1_ptr, off;
  logic [LQ_PTR_W:0]    count_q, pop_w;
  logic [LQ_DEPTH-1:0]  valid, popped, hit;
  logic                 push_hit;

  assign pop_w     = (LQ_PTR_W+1)'(pop_cnt);
  assign head1_ptr = head_q + 1'b1;
  assign push_hit  = (kill0_en && (push_rd == kill0_rd)) || (kill1_en && (push_rd == kill1_rd));

  // Per-entry occupancy, drain and kill-match flags, plus the pending bitmap.
  always_comb begin
    valid   = '0;
    popped  = '0;
    hit     = '0;
    pending = '0;
    off     = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      off       = LQ_PTR_W'(i) - head_q;
      valid[i]  = {1'b0, off} < count_q;
      popped[i] = valid[i] && ({1'b0, off} < pop_w);
      hit[i]    = (kill0_en && (rd_q[i] == kill0_rd)) || (kill1_en && (rd_q[i] == kill1_rd));
      if (valid[i] && live_q[i]) pending[rd_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  // Live-bit update: kill matching entries that stay queued; a new entry can die on arrival.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (valid[i] && !popped[i] && hit[i]) live_d[i] = 1'b0;
    end
    if (push) live_d[tail_q] = !push_hit;
  end

  // Pointer, occupancy and live-bit state.
  always_ff @(posedge clk) begin
    if (rstn == RESET_EN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      head_q  <= head_q + LQ_PTR_W'(pop_cnt);
      tail_q  <= tail_q + LQ_PTR_W'(push);
      count_q <= count_q + (LQ_PTR_W+1)'(push) - pop_w;
      live_q  <= live_d;
    end
  end

  // Entry payload; contents are meaningless until covered by count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= push_rd;
      data_q[tail_q] <= push_data;
    end
  end

  assign count       = count_q;
  assign head0_valid = count_q != '0;
  assign head0_live  = live_q[head_q];
  assign head0_rd    = rd_q[head_q];
  assign head0_data  = data_q[head_q];
  assign head1_valid = count_q > (LQ_PTR_W+1)'(1);
  assign head1_live  = live_q[head1_ptr];
  assign head1_rd    = rd_q[head1_ptr];
  assign head1_data  = data_q[head1_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Dual-issue writeback stage: merges two never-stalled ALU streams with a
// back-pressured load stream buffered in a load queue, onto two registered write ports.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = LQ_DEPTH_DEFAULT,
  parameter int unsigned LQ_PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 alu0_wen,
  input  logic [REG_IDX_W-1:0] alu0_rd,
  input  logic [XLEN-1:0]      alu0_data,
  input  logic                 alu1_wen,
  input  logic [REG_IDX_W-1:0] alu1_rd,
  input  logic [XLEN-1:0]      alu1_data,
  input  logic                 lsu_valid,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  output logic                 lsu_ready,
  output logic                 wen0,
  output logic [REG_IDX_W-1:0] wreg_id0,
  output logic [XLEN-1:0]      wreg_data0,
  output logic                 wen1,
  output logic [REG_IDX_W-1:0] wreg_id1,
  output logic [XLEN-1:0]      wreg_data1,
  output logic [NUM_REGS-1:0]  load_pending,
  output logic [LQ_PTR_W:0]    lq_count
);

  logic                 alu0_slot, alu1_slot, lq_push;
  logic [1:0]           lq_pop;
  logic                 head0_valid, head0_live, head1_valid, head1_live;
  logic [REG_IDX_W-1:0] head0_rd, head1_rd;
  logic [XLEN-1:0]      head0_data, head1_data;
  wb_mode_e             mode;
  wb_port_t             port0_d, port0_q, port1_d, port1_q, alu_single;

  // A write to x0 is architecturally void, so it never claims a port.
  assign alu0_slot = (alu0_wen == W_REG_EN) && (alu0_rd != ZERO_REG);
  assign alu1_slot = (alu1_wen == W_REG_EN) && (alu1_rd != ZERO_REG);

  // Credit comes from the registered count only; same-cycle pops do not free space.
  assign lsu_ready = (rstn != RESET_EN) && (lq_count < (LQ_PTR_W+1)'(LQ_DEPTH));
  assign lq_push   = lsu_valid && lsu_ready && (lsu_rd != ZERO_REG);

  wb_load_queue #(
    .LQ_DEPTH (LQ_DEPTH),
    .LQ_PTR_W (LQ_PTR_W)
  ) u_lq (
    .clk         (clk),
    .rstn        (rstn),
    .push        (lq_push),
    .push_rd     (lsu_rd),
    .push_data   (lsu_data),
    .pop_cnt     (lq_pop),
    .kill0_en    (alu0_slot),
    .kill0_rd    (alu0_rd),
    .kill1_en    (alu1_slot),
    .kill1_rd    (alu1_rd),
    .count       (lq_count),
    .head0_valid (head0_valid),
    .head0_live  (head0_live),
    .head0_rd    (head0_rd),
    .head0_data  (head0_data),
    .head1_valid (head1_valid),
    .head1_live  (head1_live),
    .head1_rd    (head1_rd),
    .head1_data  (head1_data),
    .pending     (load_pending)
  );

  // Classify the cycle by how many ALUs need a port.
  always_comb begin
    mode = ModeDrain;
    if (alu0_slot && alu1_slot)      mode = ModeAlus;
    else if (alu0_slot || alu1_slot) mode = ModeMixed;
  end

  // Port assignment and LQ pop count; younger results always land on port1.
  always_comb begin
    port0_d    = PORT_IDLE;
    port1_d    = PORT_IDLE;
    lq_pop     = 2'd0;
    alu_single = alu0_slot ? '{wen: W_REG_EN, rd: alu0_rd, data: alu0_data}
                           : '{wen: W_REG_EN, rd: alu1_rd, data: alu1_data};
    unique case (mode)
      ModeAlus: begin
        port0_d = '{wen: W_REG_EN, rd: alu0_rd, data: alu0_data};
        port1_d = '{wen: W_REG_EN, rd: alu1_rd, data: alu1_data};
      end
      ModeMixed: begin
        port1_d = alu_single;
        if (head0_valid) begin
          lq_pop  = 2'd1;
          port0_d = '{wen: head0_live ? W_REG_EN : ~W_REG_EN, rd: head0_rd, data: head0_data};
        end
      end
      ModeDrain: begin
        if (head0_valid) begin
          lq_pop  = 2'd1;
          port0_d = '{wen: head0_live ? W_REG_EN : ~W_REG_EN, rd: head0_rd, data: head0_data};
        end
        if (head1_valid) begin
          lq_pop  = 2'd2;
          port1_d = '{wen: head1_live ? W_REG_EN : ~W_REG_EN, rd: head1_rd, data: head1_data};
        end
      end
      default: ;
    endcase
  end

  // Registered write ports toward the register file.
  always_ff @(posedge clk) begin
    if (rstn == RESET_EN) begin
      port0_q <= PORT_IDLE;
      port1_q <= PORT_IDLE;
    end else begin
      port0_q <= port0_d;
      port1_q <= port1_d;
    end
  end

  assign wen0       = port0_q.wen;
  assign wreg_id0   = port0_q.rd;
  assign wreg_data0 = port0_q.data;
  assign wen1       = port1_q.wen;
  assign wreg_id1   = port1_q.rd;
  assign wreg_data1 = port1_q.data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: expected writes are queued per stream when stimulus is
// driven and retired by a register-file monitor as the write ports fire.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu0_wen, alu1_wen, lsu_valid, lsu_ready;
  logic [4:0]  alu0_rd, alu1_rd, lsu_rd;
  logic [31:0] alu0_data, alu1_data, lsu_data;
  logic        wen0, wen1;
  logic [4:0]  wreg_id0, wreg_id1;
  logic [31:0] wreg_data0, wreg_data1;
  logic [31:0] load_pending;
  logic [2:0]  lq_count;

  typedef logic [36:0] wr_t;  // {rd, data}
  wr_t         alu_q[$];
  wr_t         ld_q[$];
  logic [31:0] rf[32];
  int          checks = 0;
  int          errors = 0;
  logic        m_wen;
  wr_t         m_wr;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk          (clk),
    .rstn         (rstn),
    .alu0_wen     (alu0_wen),
    .alu0_rd      (alu0_rd),
    .alu0_data    (alu0_data),
    .alu1_wen     (alu1_wen),
    .alu1_rd      (alu1_rd),
    .alu1_data    (alu1_data),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .wen0         (wen0),
    .wreg_id0     (wreg_id0),
    .wreg_data0   (wreg_data0),
    .wen1         (wen1),
    .wreg_id1     (wreg_id1),
    .wreg_data1   (wreg_data1),
    .load_pending (load_pending),
    .lq_count     (lq_count)
  );

  function automatic string head_str(input wr_t q[$]);
    if (q.size() == 0) return "none";
    return $sformatf("x%0d=%h", q[0][36:32], q[0][31:0]);
  endfunction

  // Register-file monitor: port0 retires before port1; each write must be the
  // oldest outstanding ALU result or the oldest outstanding live load.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      m_wen = (p == 0) ? wen0 : wen1;
      m_wr  = (p == 0) ? {wreg_id0, wreg_data0} : {wreg_id1, wreg_data1};
      if (m_wen === 1'b1) begin
        checks++;
        if (alu_q.size() != 0 && alu_q[0] === m_wr) alu_q.delete(0);
        else if (ld_q.size() != 0 && ld_q[0] === m_wr) ld_q.delete(0);
        else begin
          errors++;
          $display("FAIL scoreboard port%0d: got x%0d=%h, expected alu %s or load %s", p,
                   m_wr[36:32], m_wr[31:0], head_str(alu_q), head_str(ld_q));
        end
        rf[m_wr[36:32]] = m_wr[31:0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both ALUs; results with a real destination are expected in issue order.
  task automatic set_alu(input logic w0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic w1, input logic [4:0] r1, input logic [31:0] d1);
    alu0_wen = w0; alu0_rd = r0; alu0_data = d0;
    alu1_wen = w1; alu1_rd = r1; alu1_data = d1;
    if (w0 && r0 != 0) alu_q.push_back({r0, d0});
    if (w1 && r1 != 0) alu_q.push_back({r1, d1});
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] r, input logic [31:0] d);
    lsu_valid = v; lsu_rd = r; lsu_data = d;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_alu(0, 0, 0, 0, 0, 0);
    set_lsu(1, 5'd3, 32'h33);
    tick(); tick();
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", lsu_ready); end
    checks++; if ({wen0, wen1} !== 2'b00) begin errors++; $display("FAIL reset_wen: got %b want 00", {wen0, wen1}); end
    checks++; if (lq_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", lq_count); end
    checks++; if (load_pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h want 0", load_pending); end
    checks++;
    if ({wreg_id0, wreg_data0, wreg_id1, wreg_data1} !== 74'd0) begin
      errors++; $display("FAIL reset_ports: got %h/%h %h/%h want zeros", wreg_id0, wreg_data0, wreg_id1, wreg_data1);
    end
    set_lsu(0, 0, 0);
    rstn = 1'b1;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", lsu_ready); end
  endtask

  task automatic test_load_only();
    set_lsu(1, 5'd5, 32'hAA);
    ld_q.push_back({5'd5, 32'hAA});
    tick();  // t1
    set_lsu(0, 0, 0);
    checks++; if (load_pending[5] !== 1'b1) begin errors++; $display("FAIL load_pending_t1: got %b want 1", load_pending[5]); end
    checks++; if ({wen0, wen1} !== 2'b00) begin errors++; $display("FAIL load_no_bypass: got %b want 00", {wen0, wen1}); end
    tick();  // t2
    checks++;
    if ({wen0, wreg_id0, wreg_data0, wen1} !== {1'b1, 5'd5, 32'hAA, 1'b0}) begin
      errors++; $display("FAIL load_writeback: got wen0=%b x%0d=%h wen1=%b want wen0=1 x5=aa wen1=0",
                         wen0, wreg_id0, wreg_data0, wen1);
    end
    checks++; if (load_pending[5] !== 1'b0) begin errors++; $display("FAIL load_pending_t2: got %b want 0", load_pending[5]); end
    checks++; if (lq_count !== 3'd0) begin errors++; $display("FAIL load_count: got %0d want 0", lq_count); end
  endtask

  task automatic test_alu_busy();
    int          exp_cnt[9] = '{1, 2, 3, 4, 4, 4, 2, 1, 0};
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        exp_rdy;
    logic [11:0] exp_p, got_p;
    for (int c = 0; c < 9; c++) begin
      if (c < 6) set_alu(1, 5'(10 + c), 32'hA000_0000 | c, 1, 5'(20 + c), 32'hB000_0000 | c);
      else       set_alu(0, 0, 0, 0, 0, 0);
      if (c < 4) begin lrd = 5'(c + 1); ldat = 32'h1000_0000 + c + 1; end
      else       begin lrd = 5'd6;      ldat = 32'h1000_0006;         end
      set_lsu(c < 8, lrd, ldat);
      exp_rdy = (c < 4) || (c >= 7);
      checks++;
      if (lsu_ready !== exp_rdy) begin errors++; $display("FAIL busy_ready c=%0d: got %b want %b", c, lsu_ready, exp_rdy); end
      if (exp_rdy && c < 8) ld_q.push_back({lrd, ldat});
      tick();
      checks++;
      if (lq_count !== 3'(exp_cnt[c])) begin
        errors++; $display("FAIL busy_count c=%0d: got %0d want %0d", c, lq_count, exp_cnt[c]);
      end
      if (c < 6)       exp_p = {1'b1, 5'(10 + c), 1'b1, 5'(20 + c)};
      else if (c == 6) exp_p = {1'b1, 5'd1, 1'b1, 5'd2};
      else if (c == 7) exp_p = {1'b1, 5'd3, 1'b1, 5'd4};
      else             exp_p = {1'b1, 5'd6, 1'b0, 5'd0};
      got_p = {wen0, wreg_id0, wen1, wreg_id1 & {5{wen1}}};
      checks++;
      if (got_p !== exp_p) begin errors++; $display("FAIL busy_ports c=%0d: got %h want %h", c, got_p, exp_p); end
    end
  endtask

  task automatic test_waw_kill();
    set_alu(1, 5'd11, 32'hA100_0000, 1, 5'd21, 32'hB100_0000);
    set_lsu(1, 5'd7, 32'h77);  // killed below, so never expected on a port
    tick();
    set_lsu(0, 0, 0);
    set_alu(1, 5'd7, 32'h1, 1, 5'd22, 32'hB200_0000);
    checks++; if (load_pending[7] !== 1'b1) begin errors++; $display("FAIL kill_pending_before: got %b want 1", load_pending[7]); end
    tick();
    set_alu(0, 0, 0, 0, 0, 0);
    checks++; if (load_pending[7] !== 1'b0) begin errors++; $display("FAIL kill_pending_after: got %b want 0", load_pending[7]); end
    tick();  // dead entry drains without a write
    checks++; if (lq_count !== 3'd0) begin errors++; $display("FAIL kill_dead_pop: got %0d want 0", lq_count); end
    set_alu(1, 5'd8, 32'h8, 0, 0, 0);
    set_lsu(1, 5'd8, 32'h88);  // same-cycle kill of the entry being enqueued
    tick();
    set_alu(0, 0, 0, 0, 0, 0);
    set_lsu(0, 0, 0);
    checks++;
    if ({lq_count, load_pending[8]} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL kill_enqueue: got count=%0d pend8=%b want count=1 pend8=0", lq_count, load_pending[8]);
    end
    tick(); tick();
    checks++; if (rf[7] !== 32'h1) begin errors++; $display("FAIL kill_rf_x7: got %h want 1", rf[7]); end
    checks++; if (rf[8] !== 32'h8) begin errors++; $display("FAIL kill_rf_x8: got %h want 8", rf[8]); end
  endtask

  task automatic test_port_order();
    set_lsu(1, 5'd9, 32'h2);
    ld_q.push_back({5'd9, 32'h2});
    tick();
    set_lsu(0, 0, 0);
    set_alu(0, 0, 0, 1, 5'd9, 32'h3);
    tick();
    checks++;
    if ({wen0, wreg_id0, wreg_data0, wen1, wreg_id1, wreg_data1} !==
        {1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 32'h3}) begin
      errors++; $display("FAIL order_ports: got %b x%0d=%h / %b x%0d=%h want 1 x9=2 / 1 x9=3",
                         wen0, wreg_id0, wreg_data0, wen1, wreg_id1, wreg_data1);
    end
    set_alu(1, 5'd14, 32'hA400_0000, 1, 5'd15, 32'hB400_0000);
    set_lsu(1, 5'd12, 32'h1200);
    ld_q.push_back({5'd12, 32'h1200});
    tick();
    set_alu(1, 5'd16, 32'hA500_0000, 1, 5'd17, 32'hB500_0000);
    set_lsu(1, 5'd13, 32'h1300);
    ld_q.push_back({5'd13, 32'h1300});
    tick();
    set_lsu(0, 0, 0);
    set_alu(1, 5'd0, 32'hDEAD, 0, 0, 0);  // x0 result claims no port
    tick();
    set_alu(0, 0, 0, 0, 0, 0);
    checks++;
    if ({wen0, wreg_id0, wen1, wreg_id1} !== {1'b1, 5'd12, 1'b1, 5'd13}) begin
      errors++; $display("FAIL x0_alu_drain2: got %b x%0d %b x%0d want 1 x12 1 x13", wen0, wreg_id0, wen1, wreg_id1);
    end
    checks++; if (rf[9] !== 32'h3) begin errors++; $display("FAIL order_rf_x9: got %h want 3", rf[9]); end
  endtask

  task automatic test_wrap();
    int   cnt_m = 0;
    int   n     = 0;
    int   pops;
    logic exp_rdy;
    for (int c = 0; c < 24; c++) begin
      if (c < 4)       set_alu(1, 5'd30, 32'hC000_0000 | c, 1, 5'd31, 32'hD000_0000 | c);
      else if (c < 20) set_alu(1, 5'd31, 32'hE000_0000 | c, 0, 0, 0);
      else             set_alu(0, 0, 0, 0, 0, 0);
      set_lsu(c < 20, 5'(1 + n % 29), 32'h3000_0000 + n);
      exp_rdy = cnt_m < 4;
      checks++;
      if (lsu_ready !== exp_rdy) begin errors++; $display("FAIL wrap_ready c=%0d: got %b want %b", c, lsu_ready, exp_rdy); end
      if (c < 4)       pops = 0;
      else if (c < 20) pops = (cnt_m > 0) ? 1 : 0;
      else             pops = (cnt_m > 1) ? 2 : cnt_m;
      if (c < 20 && exp_rdy) begin
        ld_q.push_back({5'(1 + n % 29), 32'h3000_0000 + n});
        n++;
        cnt_m++;
      end
      cnt_m -= pops;
      tick();
      checks++;
      if (lq_count !== 3'(cnt_m)) begin errors++; $display("FAIL wrap_count c=%0d: got %0d want %0d", c, lq_count, cnt_m); end
    end
    set_lsu(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      set_alu(1, 5'(20 + c), 32'hF000_0000 | c, 1, 5'(24 + c), 32'hF100_0000 | c);
      set_lsu(1, 5'(10 + c), 32'h4000_0000 + c);
      ld_q.push_back({5'(10 + c), 32'h4000_0000 + c});
      tick();
    end
    set_alu(0, 0, 0, 0, 0, 0);
    set_lsu(1, 5'd18, 32'h18);
    checks++;
    if ({lq_count, load_pending} !== {3'd3, 32'h0000_1C00}) begin
      errors++; $display("FAIL pre_reset_state: got count=%0d pend=%h want count=3 pend=00001c00", lq_count, load_pending);
    end
    rstn = 1'b0;
    ld_q.delete();  // queued loads are discarded by reset
    #1;
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", lsu_ready); end
    tick();
    set_lsu(0, 0, 0);
    checks++;
    if ({wen0, wen1, lq_count, load_pending} !== 37'd0) begin
      errors++; $display("FAIL mid_reset_state: got wen=%b%b count=%0d pend=%h want all zero",
                         wen0, wen1, lq_count, load_pending);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if ({wen0, wen1} !== 2'b00) begin errors++; $display("FAIL post_reset_quiet: got %b want 00", {wen0, wen1}); end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'h0;
    test_reset();
    test_load_only();
    test_alu_busy();
    test_waw_kill();
    test_port_order();
    test_wrap();
    test_reset_mid();
    tick(); tick();
    checks++; if (alu_q.size() != 0) begin errors++; $display("FAIL alu_leftover: got %0d want 0", alu_q.size()); end
    checks++; if (ld_q.size() != 0) begin errors++; $display("FAIL load_leftover: got %0d want 0", ld_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
